// File: rtl/ht_pkg.sv
// Shared types and defaults for the ht block and its upstream frame loader.
package ht_pkg;

    localparam int HT_INDEX = 8;
    localparam int HT_WIDTH = 4;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } ht_ld_state_e;

    typedef logic [HT_WIDTH-1:0] ht_frame_t [0:HT_INDEX-1];

endpackage

// File: rtl/ht_frame_loader.sv
// Serial-to-parallel frame loader feeding ht: fills indata, pulses start, waits for over.
// Optional framing check on in_last is enabled by defining HT_LOADER_LAST_CHECK_EN.
module ht_frame_loader
    import ht_pkg::*;
#(
    parameter int index       = HT_INDEX,
    parameter int width       = HT_WIDTH,
    parameter int index_width = $clog2(index)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [width-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic [width-1:0] indata [0:index-1],
    output logic             start,
    input  logic             over,
    output logic             busy,
    output logic             frame_err
);

    localparam logic [index_width-1:0] LAST_IDX = index_width'(index - 1);

    ht_ld_state_e           r_state;
    logic [index_width-1:0] r_wr_idx;
    logic [width-1:0]       r_indata [0:index-1];
    logic                   w_beat;
    logic                   w_last_idx;

    // All handshake outputs decode from registered state only.
    assign in_ready   = (r_state == FILL);
    assign start      = (r_state == START);
    assign busy       = (r_state != FILL);
    assign indata     = r_indata;
    assign w_beat     = in_valid & in_ready;
    assign w_last_idx = (r_wr_idx == LAST_IDX);

`ifdef HT_LOADER_LAST_CHECK_EN
    logic r_frame_err;
    assign frame_err = r_frame_err;
`else
    // in_last has no role when frames are delimited purely by count.
    assign frame_err = in_last & 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= FILL;
            r_wr_idx <= '0;
            for (int i = 0; i < index; i++) begin
                r_indata[i] <= '0;
            end
`ifdef HT_LOADER_LAST_CHECK_EN
            r_frame_err <= 1'b0;
`endif
        end else begin
`ifdef HT_LOADER_LAST_CHECK_EN
            r_frame_err <= 1'b0;
`endif
            case (r_state)
                FILL: begin
                    if (w_beat) begin
                        r_indata[r_wr_idx] <= in_data;
`ifdef HT_LOADER_LAST_CHECK_EN
                        // A misplaced or missing in_last discards the frame in progress.
                        if (w_last_idx) begin
                            r_wr_idx <= '0;
                            if (in_last) begin
                                r_state <= START;
                            end else begin
                                r_frame_err <= 1'b1;
                            end
                        end else if (in_last) begin
                            r_wr_idx    <= '0;
                            r_frame_err <= 1'b1;
                        end else begin
                            r_wr_idx <= r_wr_idx + index_width'(1);
                        end
`else
                        if (w_last_idx) begin
                            r_wr_idx <= '0;
                            r_state  <= START;
                        end else begin
                            r_wr_idx <= r_wr_idx + index_width'(1);
                        end
`endif
                    end
                end
                START: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (over) begin
                        r_state <= FILL;
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ht_frame_loader.sv
// Directed self-checking bench for ht_frame_loader (index=8, width=4).
// Covers the in_last framing check when HT_LOADER_LAST_CHECK_EN is defined.
module tb_ht_frame_loader;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic [3:0] indata [0:7];
    logic       start;
    logic       over;
    logic       busy;
    logic       frame_err;

    int assertCount = 0;
    int failCount   = 0;
    int startCount  = 0;
    int expStarts   = 0;

    ht_frame_loader #(.index(8), .width(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .indata    (indata),
        .start     (start),
        .over      (over),
        .busy      (busy),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tally every start pulse so unexpected extra pulses are caught at the end.
    always @(posedge clk) begin
        if (start) startCount <= startCount + 1;
    end

    function automatic logic [31:0] packFrame();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v = {v[27:0], indata[i]};
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and hold it until the loader accepts it.
    task automatic applyStimulus(input logic [3:0] data, input logic last);
        int waitCycles;
        waitCycles = 0;
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        while (!in_ready && waitCycles < 50) begin
            tick();
            waitCycles++;
        end
        if (!in_ready) begin
            checkOutput("readyTimeout", 32'd0, 32'd1);
        end else begin
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic sendFrame(input logic [31:0] frame, input int maxGap);
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < $urandom_range(maxGap, 0); g++) tick();
            applyStimulus(frame[31-4*i -: 4], (i == 7));
            if (i == 6) begin
                checkOutput("noEarlyStart", {31'd0, start}, 32'd0);
                checkOutput("readyMidFrame", {31'd0, in_ready}, 32'd1);
            end
        end
    endtask

    task automatic pulseOver();
        over = 1'b1;
        tick();
        over = 1'b0;
        checkOutput("readyAfterOver", {31'd0, in_ready}, 32'd1);
        checkOutput("busyAfterOver", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        over     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("resetReady", {31'd0, in_ready}, 32'd1);
        checkOutput("resetStart", {31'd0, start}, 32'd0);
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        checkOutput("resetErr", {31'd0, frame_err}, 32'd0);
        checkOutput("resetData", packFrame(), 32'h0000_0000);

        $display("[TB] frame 1: back-to-back 1..8");
        sendFrame(32'h1234_5678, 0);
        expStarts++;
        checkOutput("f1Start", {31'd0, start}, 32'd1);
        checkOutput("f1Busy", {31'd0, busy}, 32'd1);
        checkOutput("f1Ready", {31'd0, in_ready}, 32'd0);
        checkOutput("f1Data", packFrame(), 32'h1234_5678);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("f1StartOnce", {31'd0, start}, 32'd0);
            checkOutput("f1WaitReady", {31'd0, in_ready}, 32'd0);
            checkOutput("f1WaitBusy", {31'd0, busy}, 32'd1);
        end
        pulseOver();
        checkOutput("f1DataHeld", packFrame(), 32'h1234_5678);

        $display("[TB] frame 2: F..8");
        sendFrame(32'hFEDC_BA98, 0);
        expStarts++;
        checkOutput("f2Start", {31'd0, start}, 32'd1);
        checkOutput("f2Data", packFrame(), 32'hFEDC_BA98);

        // over raised while in START must be ignored.
        over = 1'b1;
        tick();
        over = 1'b0;
        checkOutput("overInStartBusy", {31'd0, busy}, 32'd1);
        checkOutput("overInStartReady", {31'd0, in_ready}, 32'd0);
        checkOutput("overInStartNoStart", {31'd0, start}, 32'd0);
        tick();
        checkOutput("stillWaiting", {31'd0, busy}, 32'd1);
        pulseOver();

        // over raised while in FILL must be ignored.
        over = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("overInFillReady", {31'd0, in_ready}, 32'd1);
            checkOutput("overInFillStart", {31'd0, start}, 32'd0);
        end
        over = 1'b0;

        $display("[TB] frame 3: A..1 with random gaps");
        sendFrame(32'hABCD_EF01, 3);
        expStarts++;
        checkOutput("f3Start", {31'd0, start}, 32'd1);
        checkOutput("f3Data", packFrame(), 32'hABCD_EF01);
        tick();
        pulseOver();

        $display("[TB] reset while waiting");
        sendFrame(32'h3456_789A, 0);
        expStarts++;
        tick();
        checkOutput("preResetBusy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rstWaitBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstWaitReady", {31'd0, in_ready}, 32'd1);
        checkOutput("rstWaitData", packFrame(), 32'h0000_0000);

        // A partial fill interrupted by reset must restart at index 0.
        applyStimulus(4'h7, 1'b0);
        applyStimulus(4'h7, 1'b0);
        applyStimulus(4'h7, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sendFrame(32'h1234_5678, 0);
        expStarts++;
        checkOutput("postRstStart", {31'd0, start}, 32'd1);
        checkOutput("postRstData", packFrame(), 32'h1234_5678);
        tick();
        pulseOver();

`ifdef HT_LOADER_LAST_CHECK_EN
        $display("[TB] framing check: early in_last");
        for (int i = 1; i <= 5; i++) applyStimulus(4'(i), (i == 5));
        checkOutput("earlyLastErr", {31'd0, frame_err}, 32'd1);
        checkOutput("earlyLastNoStart", {31'd0, start}, 32'd0);
        checkOutput("earlyLastReady", {31'd0, in_ready}, 32'd1);
        tick();
        checkOutput("errOneCycle", {31'd0, frame_err}, 32'd0);
        sendFrame(32'h89AB_CDEF, 0);
        expStarts++;
        checkOutput("afterErrStart", {31'd0, start}, 32'd1);
        checkOutput("afterErrData", packFrame(), 32'h89AB_CDEF);
        checkOutput("afterErrNoErr", {31'd0, frame_err}, 32'd0);
        tick();
        pulseOver();
`endif

        // Partial refill overwrites only the leading entries.
        applyStimulus(4'h9, 1'b0);
        applyStimulus(4'h9, 1'b0);
        applyStimulus(4'h9, 1'b0);
`ifdef HT_LOADER_LAST_CHECK_EN
        checkOutput("partialData", packFrame(), 32'h999B_CDEF);
`else
        checkOutput("partialData", packFrame(), 32'h9994_5678);
`endif
        checkOutput("partialNoStart", {31'd0, start}, 32'd0);
        tick();
        checkOutput("startCount", 32'(startCount), 32'(expStarts));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/ht_frame_loader.md
# ht_frame_loader

Upstream feeder for the `ht` block. Accepts a serial stream of `width`-bit samples over a valid/ready handshake, assembles `index` samples into a frame buffer, and presents the frame on the parallel `indata` array. It then issues a one-cycle `start` to `ht` and holds the frame stable until `ht` reports `over`, after which it accepts the next frame.

## Interface
- `index`, 8, samples per frame; must be ≥ 2
- `width`, 4, bits per sample
- `index_width`, `$clog2(index)`, width of the write pointer
- `clk`  in  1  system clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  upstream sample valid
- `in_data`  in  `width`  upstream sample
- `in_last`  in  1  marks the final sample of a frame; used only under `HT_LOADER_LAST_CHECK_EN`
- `in_ready`  out  1  loader can accept a sample
- `indata`  out  `[width-1:0] [0:index-1]`  frame buffer, wired to `ht.indata`
- `start`  out  1  one-cycle pulse to `ht`: frame valid, begin processing
- `over`  in  1  `ht` completion; sampled as a level
- `busy`  out  1  a frame is issued and not yet completed
- `frame_err`  out  1  one-cycle pulse on a framing error; tied 0 without the macro

## Operation
- Clocking: single clock `clk`. Reset: synchronous and active-high on `rst`.
- States (registered): FILL, START, WAIT.
- FILL: `in_ready`=1. On each beat (`in_valid & in_ready`), write `in_data` to `indata[wr_idx]` and increment `wr_idx`. On the beat with `wr_idx == index-1`, clear `wr_idx` to 0 and go to START.
- START: `start`=1 and `in_ready`=0 for exactly one cycle. `over` is ignored in this state. Go to WAIT.
- WAIT: `in_ready`=0 and `busy`=1. When `over`=1, go to FILL. `indata` is not modified.
- `over` asserted in FILL is ignored.
- `indata` holds its contents after completion. Entries are overwritten only by new beats, so a partially refilled buffer mixes old and new samples. `ht` must only sample `indata` on `start`.
- `wr_idx` wraps from `index-1` to 0, with no overflow past `index`.
- Reset in any state: state becomes FILL, `wr_idx`=0, `indata` all zeros, `start`=0, `busy`=0, `frame_err`=0, and `in_ready`=1 in the cycle after reset deasserts.
- Arithmetic: `wr_idx` is `index_width` bits. `index` need not be a power of two; the compare is against `index-1`.

## Timing
- `in_ready` is decoded from registered state only, with no combinational path from `in_valid`.
- Final beat accepted at edge N: `start`=1 during cycle N+1. `indata` is fully valid from N+1. `busy`=1 from N+1.
- `over` sampled high at edge M (state WAIT): `busy`=0 and `in_ready`=1 from cycle M+1.
- Minimum frame period is `index` + 2 + (`ht` latency) cycles.
- If `in_valid` is low, the loader inserts no bubbles and simply waits. Gaps mid-frame are allowed.

## Configuration
- `HT_LOADER_LAST_CHECK_EN` defined:
  - `in_last` high on a beat with `wr_idx != index-1`: pulse `frame_err`, discard the partial frame (`wr_idx`=0), stay in FILL, and issue no `start`.
  - `in_last` low on the beat with `wr_idx == index-1`: pulse `frame_err`, discard the frame, and stay in FILL.
  - `frame_err` pulses in the cycle after the offending beat.
- Not defined: `in_last` is ignored, `frame_err` is constant 0, and frames are delimited purely by count.

## Structure
- Shared package `ht_pkg`:
  - state enum `ht_ld_state_e` (FILL/START/WAIT)
  - default `HT_INDEX`=8 and `HT_WIDTH`=4
  - the frame array typedef, also used by `ht`
- No sub-module: buffer, pointer and FSM fit in one module.

## Test plan
- Reset, then stream 1,2,…,8 with `in_valid` held high: `start` pulses once on the cycle after the 8th beat, `indata` = {1,…,8}, and `in_ready`=0 until `over`.
- `over` is pulsed 5 cycles after `start`: `in_ready`=1 on the next cycle. A second frame of F,E,…,8 replaces `indata` exactly, and `start` pulses again.
- Random `in_valid` gaps while streaming A,B,…: frame contents are identical and in order, and `start` occurs only after the 8th accepted beat.
- `over` driven high during FILL and during START: no state change and no extra `start`.
- `rst` asserted in WAIT with `over`=0: next cycle state is FILL, `indata` is all 0, and `busy`=0.
- With the macro defined, `in_last` on beat 5: `frame_err` pulses once, no `start` follows, and the following 8-beat frame with `in_last` on beat 8 issues `start` normally.
